scanline_output: RTL and testbench

//  Parametrised ping-pong scanline buffer and VGA scan-out stage.
//  The sprite/tile drawers write palette indices into the back line. The display

---
 rtl/scanline_output.sv | 116 +++++++++++
 tb/tb_scanline_output.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scanline_output.sv
// scanline_output: ping-pong palette-index line buffer with hardware clear, horizontal scaling and aligned VGA scan-out
//  clk_pix                 pixel clock
//  btn_rst                 asynchronous active-low reset
//  wr_en/wr_x/wr_idx       drawer write port into the back line
//  wr_clear                start clearing the back line to index 0
//  line_swap               exchange front and back lines
//  err_clear               clear sticky error flags
//  sx/sy/de/hsync/vsync    raw display timing (sy is not used)
//  pal_addr/pal_data       palette RAM read port, 1-cycle latency
//  bg_color                colour shown for index 0
//  vga_r/g/b/hsync/vsync   pins, 3 cycles after timing inputs
//  clear_busy              clear in progress
//  err_overrun/err_drop    sticky swap-during-clear / write-during-clear flags
module scanline_output #(
  parameter int   H_RES      = 640,
  parameter int   CORDW      = 10,
  parameter int   INDEX_W    = 8,
  parameter int   COMP_W     = 8,
  parameter int   CHAN_W     = 4,
  parameter int   SCALE_LOG2 = 0,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic                  clk_pix,
  input  logic                  btn_rst,
  input  logic                  wr_en,
  input  logic [CORDW-1:0]      wr_x,
  input  logic [INDEX_W-1:0]    wr_idx,
  input  logic                  wr_clear,
  input  logic                  line_swap,
  input  logic                  err_clear,
  input  logic [CORDW-1:0]      sx,
  input  logic [CORDW-1:0]      sy,
  input  logic                  de,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic [INDEX_W-1:0]    pal_addr,
  input  logic [3*COMP_W-1:0]   pal_data,
  input  logic [3*CHAN_W-1:0]   bg_color,
  output logic [CHAN_W-1:0]     vga_r,
  output logic [CHAN_W-1:0]     vga_g,
  output logic [CHAN_W-1:0]     vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  clear_busy,
  output logic                  err_overrun,
  output logic                  err_drop
);
  localparam int DEPTH = H_RES >> SCALE_LOG2;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CORDW-1:0] X_END = CORDW'(H_RES);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [AW-1:0] clr_cnt, wa, ra;
  logic [INDEX_W-1:0] line0 [DEPTH];
  logic [INDEX_W-1:0] line1 [DEPTH];
  logic [INDEX_W-1:0] wd, rd, s1_idx;
  logic front_sel, swap_pending, clearing, clr_done, swap_now, we, vis;
  logic s1_vis, s2_vis, s2_zero;
  logic [2:0] hs_d, vs_d;
  logic unused_in;
  assign unused_in = ^{sy, pal_data};
  always_comb begin
    clearing = state == CLEAR;
    clr_done = clearing && clr_cnt == AW'(DEPTH - 1);
    state_nx = clearing ? (clr_done ? IDLE : CLEAR) : (wr_clear ? CLEAR : IDLE);
    // a swap requested during a clear is held until the clear's last write
    swap_now = clearing ? clr_done && (swap_pending || line_swap) : line_swap;
    we = clearing || (wr_en && wr_x < X_END);
    wa = clearing ? clr_cnt : AW'(wr_x >> SCALE_LOG2);
    wd = clearing ? '0 : wr_idx;
    vis = de && sx < X_END;
    ra = AW'(sx >> SCALE_LOG2);
    rd = front_sel ? line1[ra] : line0[ra];
    clear_busy = clearing;
  end
  // back line is the one not selected as front
  always_ff @(posedge clk_pix)
    if (we) begin
      if (front_sel) line0[wa] <= wd;
      else line1[wa] <= wd;
    end
  always_ff @(posedge clk_pix or negedge btn_rst)
    if (!btn_rst) begin
      state <= IDLE;
      clr_cnt <= '0;
      front_sel <= 1'b0;
      swap_pending <= 1'b0;
      err_overrun <= 1'b0;
      err_drop <= 1'b0;
      s1_idx <= '0;
      s1_vis <= 1'b0;
      s2_vis <= 1'b0;
      s2_zero <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
      hs_d <= {3{SYNC_IDLE}};
      vs_d <= {3{SYNC_IDLE}};
    end else begin
      state <= state_nx;
      clr_cnt <= clearing && !clr_done ? clr_cnt + 1'b1 : '0;
      front_sel <= front_sel ^ swap_now;
      swap_pending <= clearing && !clr_done && (swap_pending || line_swap);
      err_overrun <= !err_clear && (err_overrun || (clearing && line_swap));
      err_drop <= !err_clear && (err_drop || (clearing && wr_en));
      s1_idx <= vis ? rd : '0;
      s1_vis <= vis;
      s2_vis <= s1_vis;
      s2_zero <= s1_idx == '0;
      {vga_r, vga_g, vga_b} <= !s2_vis ? '0 : s2_zero ? bg_color :
        {pal_data[3*COMP_W-1 -: CHAN_W], pal_data[2*COMP_W-1 -: CHAN_W], pal_data[COMP_W-1 -: CHAN_W]};
      hs_d <= {hs_d[1:0], hsync};
      vs_d <= {vs_d[1:0], vsync};
    end
  assign pal_addr = s1_idx;
  assign vga_hsync = hs_d[2];
  assign vga_vsync = vs_d[2];
endmodule

// File: tb/tb_scanline_output.sv
// tb_scanline_output: random and directed stimulus for two scanline_output instances (unscaled and 2x) against a line-level reference model
module tb_scanline_output;
  logic clk_pix = 1'b0, btn_rst = 1'b0;
  logic wr_en = 1'b0, wr_clear = 1'b0, line_swap = 1'b0, err_clear = 1'b0;
  logic de = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0] wr_x = '0, sx = '0, sy = '0;
  logic [7:0] wr_idx = '0;
  logic [11:0] bg_color = 12'h123;
  logic [7:0] pal_addr [2];
  logic [23:0] pal_data [2];
  logic [3:0] vga_r [2], vga_g [2], vga_b [2];
  logic vga_hsync [2], vga_vsync [2], clear_busy [2], err_overrun [2], err_drop [2];
  typedef struct {bit vis; logic [7:0] idx; logic hs; logic vs;} pix_t;
  logic [7:0] mm [2][2][640];
  int front_m [2], clr_left [2], clr_pos [2];
  bit pend [2], ovr [2], drop [2];
  pix_t q0 [$], q1 [$];
  int n_chk = 0, n_fail = 0, busy_cnt;
  always #5 clk_pix = ~clk_pix;
  function automatic logic [23:0] pal_fn(logic [7:0] i);
    return i == 8'd7 ? 24'hA53CF0 : {i ^ 8'h5A, i * 8'd37, ~i};
  endfunction
  function automatic logic [11:0] rgb_of(logic [23:0] p);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction
  always @(posedge clk_pix) begin
    pal_data[0] <= pal_fn(pal_addr[0]);
    pal_data[1] <= pal_fn(pal_addr[1]);
  end
  scanline_output u0 (
    .clk_pix(clk_pix), .btn_rst(btn_rst), .wr_en(wr_en), .wr_x(wr_x), .wr_idx(wr_idx),
    .wr_clear(wr_clear), .line_swap(line_swap), .err_clear(err_clear), .sx(sx), .sy(sy),
    .de(de), .hsync(hsync), .vsync(vsync), .pal_addr(pal_addr[0]), .pal_data(pal_data[0]),
    .bg_color(bg_color), .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]),
    .vga_hsync(vga_hsync[0]), .vga_vsync(vga_vsync[0]), .clear_busy(clear_busy[0]),
    .err_overrun(err_overrun[0]), .err_drop(err_drop[0])
  );
  scanline_output #(.SCALE_LOG2(1)) u1 (
    .clk_pix(clk_pix), .btn_rst(btn_rst), .wr_en(wr_en), .wr_x(wr_x), .wr_idx(wr_idx),
    .wr_clear(wr_clear), .line_swap(line_swap), .err_clear(err_clear), .sx(sx), .sy(sy),
    .de(de), .hsync(hsync), .vsync(vsync), .pal_addr(pal_addr[1]), .pal_data(pal_data[1]),
    .bg_color(bg_color), .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]),
    .vga_hsync(vga_hsync[1]), .vga_vsync(vga_vsync[1]), .clear_busy(clear_busy[1]),
    .err_overrun(err_overrun[1]), .err_drop(err_drop[1])
  );
  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: got %0h expected %0h", tag, k, got, exp);
    end
  endtask
  task automatic model_reset();
    pix_t idle;
    idle = '{vis: 1'b0, idx: 8'd0, hs: 1'b1, vs: 1'b1};
    for (int k = 0; k < 2; k++) begin
      front_m[k] = 0; clr_left[k] = 0; clr_pos[k] = 0;
      pend[k] = 1'b0; ovr[k] = 1'b0; drop[k] = 1'b0;
    end
    q0 = '{idle, idle};
    q1 = '{idle, idle};
  endtask
  task automatic chk_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_rgb", k, {vga_r[k], vga_g[k], vga_b[k]}, 12'h000);
      chk("rst_sync", k, {vga_hsync[k], vga_vsync[k]}, 2'b11);
      chk("rst_pal", k, pal_addr[k], 8'h00);
      chk("rst_flags", k, {clear_busy[k], err_overrun[k], err_drop[k]}, 3'b000);
    end
  endtask
  task automatic tick();
    pix_t p;
    logic [11:0] e;
    for (int k = 0; k < 2; k++) begin
      p.vis = de && sx < 10'd640;
      p.idx = p.vis ? mm[k][front_m[k]][int'(sx) >> k] : 8'd0;
      p.hs = hsync;
      p.vs = vsync;
      if (k == 0) q0.push_back(p); else q1.push_back(p);
      if (clr_left[k] == 0) begin
        if (wr_en && wr_x < 10'd640) mm[k][1 - front_m[k]][int'(wr_x) >> k] = wr_idx;
        if (line_swap) front_m[k] = 1 - front_m[k];
        if (wr_clear) begin clr_left[k] = 640 >> k; clr_pos[k] = 0; end
      end else begin
        mm[k][1 - front_m[k]][clr_pos[k]] = 8'd0;
        clr_pos[k]++;
        clr_left[k]--;
        if (wr_en) drop[k] = 1'b1;
        if (line_swap) begin pend[k] = 1'b1; ovr[k] = 1'b1; end
        if (clr_left[k] == 0 && pend[k]) begin front_m[k] = 1 - front_m[k]; pend[k] = 1'b0; end
      end
      if (err_clear) begin ovr[k] = 1'b0; drop[k] = 1'b0; end
    end
    @(posedge clk_pix);
    #1;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? q0.pop_front() : q1.pop_front();
      e = !p.vis ? 12'h000 : p.idx == 8'd0 ? bg_color : rgb_of(pal_fn(p.idx));
      chk("rgb", k, {vga_r[k], vga_g[k], vga_b[k]}, e);
      chk("sync", k, {vga_hsync[k], vga_vsync[k]}, {p.hs, p.vs});
      chk("pal_addr", k, pal_addr[k], (k == 0) ? q0[$].idx : q1[$].idx);
      chk("flags", k, {clear_busy[k], err_overrun[k], err_drop[k]}, {clr_left[k] > 0, ovr[k], drop[k]});
    end
  endtask
  task automatic pix(int s, bit en);
    sx = 10'(s);
    de = en;
    hsync = 1'($urandom);
    vsync = 1'($urandom);
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    chk_reset();
    btn_rst = 1'b1;
    for (int x = 0; x < 640; x++) begin
      wr_en = 1'b1; wr_x = 10'(x); wr_idx = 8'(x);
      tick();
    end
    foreach (wr_x[i]) ;
    wr_x = 10'd640; wr_idx = 8'hEE; tick();
    wr_x = 10'd641; tick();
    wr_x = 10'd1023; tick();
    wr_en = 1'b0; line_swap = 1'b1; tick(); line_swap = 1'b0;
    for (int s = 0; s < 700; s++) begin
      pix(s, s < 650);
      wr_en = s < 640; wr_x = 10'(s);
      wr_idx = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      tick();
      if (s == 2) chk("bg_idx0", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'h123);
      if (s == 9) chk("idx7_rgb", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'hA3F);
      if (s == 9) chk("idx7_rgb", 1, {vga_r[1], vga_g[1], vga_b[1]}, 12'hA3F);
    end
    wr_en = 1'b1; wr_x = 10'd10; wr_idx = 8'd9; tick();
    wr_x = 10'd641; wr_idx = 8'h33; tick();
    wr_en = 1'b0; line_swap = 1'b1; tick(); line_swap = 1'b0;
    for (int s = 0; s < 30; s++) begin
      pix(s, 1'b1);
      tick();
      if (s == 12 || s == 13) chk("scale_x2", 1, {vga_r[1], vga_g[1], vga_b[1]}, 12'h54F);
      if (s == 12) chk("scale_x1", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'h54F);
    end
    busy_cnt = 0;
    for (int i = 0; i < 700; i++) begin
      pix(i, 1'b0);
      wr_clear = i == 0 || i == 100;
      line_swap = i == 4;
      wr_en = i == 20; wr_x = 10'd30; wr_idx = 8'd55;
      tick();
      busy_cnt += int'(clear_busy[0]);
    end
    {wr_clear, line_swap, wr_en} = 3'b000;
    chk("busy_len", 0, busy_cnt, 640);
    chk("ovr_sticky", 0, err_overrun[0], 1'b1);
    chk("drop_sticky", 0, err_drop[0], 1'b1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    line_swap = 1'b1; wr_clear = 1'b1; tick(); line_swap = 1'b0; wr_clear = 1'b0;
    for (int s = 0; s < 700; s++) begin pix(s, s < 640); tick(); end
    line_swap = 1'b1; tick(); line_swap = 1'b0;
    for (int s = 0; s < 700; s++) begin
      pix(s, s < 640);
      tick();
      if (s == 302) chk("cleared_bg", 0, {vga_r[0], vga_g[0], vga_b[0]}, 12'h123);
    end
    for (int s = 0; s < 400; s++) begin
      pix(s, 1'b1);
      if (s == 200) begin
        btn_rst = 1'b0;
        #1;
        chk_reset();
        @(posedge clk_pix);
        #1;
        btn_rst = 1'b1;
        model_reset();
      end
      tick();
    end
    for (int i = 0; i < 4000; i++) begin
      pix(i % 800, (i % 800 < 640) ^ ($urandom_range(0, 15) == 0));
      wr_en = 1'($urandom);
      wr_x = 10'($urandom_range(0, 700));
      wr_idx = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      wr_clear = $urandom_range(0, 299) == 0;
      line_swap = $urandom_range(0, 119) == 0;
      err_clear = $urandom_range(0, 199) == 0;
      if (i % 800 == 700) bg_color = 12'($urandom);
      tick();
    end
    {wr_en, wr_clear, line_swap, err_clear} = 4'b0000;
    for (int s = 0; s < 700; s++) begin pix(s, 1'b0); tick(); end
    wr_clear = 1'b1; tick(); wr_clear = 1'b0;
    repeat (10) begin pix(5, 1'b0); tick(); end
    chk("busy_mid", 0, clear_busy[0], 1'b1);
    btn_rst = 1'b0;
    #1;
    chk_reset();
    @(posedge clk_pix);
    #1;
    btn_rst = 1'b1;
    model_reset();
    repeat (5) begin pix(5, 1'b0); tick(); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
